// File: rtl/dma_priority_arbiter.sv
// Request resolver for the 4-channel DMA controller: masks, polarity and
// fixed/rotating priority select one channel and track it through its service.
module dma_priority_arbiter #(
  parameter int unsigned NCH           = 4,
  parameter int unsigned GRANT_TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NCH-1:0]         DREQ,
  input  logic [NCH-1:0]         maskReg,
  input  logic [NCH-1:0]         requestReg,
  input  logic [7:0]             commandReg,
  input  logic                   validDACK,
  input  logic                   svcDone,
  output logic [NCH-1:0]         VALID_DREQ,
  output logic [NCH-1:0]         DACK,
  output logic [$clog2(NCH)-1:0] activeCh,
  output logic                   busy,
  output logic [NCH-1:0]         reqStatus,
  output logic [NCH-1:0]         swReqClr,
  output logic                   grantTimeout
);

  localparam int unsigned PW = $clog2(NCH);
  localparam int unsigned CW = $clog2(GRANT_TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]     r_state, w_state_nxt;
  logic [PW-1:0]  r_ptr, w_ptr_nxt;
  logic [PW-1:0]  r_active_ch, w_active_nxt;
  logic [NCH-1:0] r_valid, w_valid_nxt;
  logic [NCH-1:0] r_req_status;
  logic [NCH-1:0] r_swclr, w_swclr_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_tout, w_tout_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt;

  logic [NCH-1:0] w_eff;
  logic [PW-1:0]  w_ptr_use;
  logic [PW-1:0]  w_sel;
  logic           w_found;
  logic           w_unused_cmd;

  assign w_unused_cmd = ^{commandReg[5], commandReg[3], commandReg[1:0]};

  // Software requests bypass the mask; hardware requests honour polarity and mask.
  assign w_eff     = ((DREQ ^ {NCH{commandReg[6]}}) & ~maskReg) | requestReg;
  assign w_ptr_use = commandReg[4] ? r_ptr : '0;

  // Search starting at the pointer; the first requesting channel wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      if (!w_found && w_eff[PW'((32'(w_ptr_use) + j) % NCH)]) begin
        w_found = 1'b1;
        w_sel   = PW'((32'(w_ptr_use) + j) % NCH);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_active_nxt = r_active_ch;
    w_valid_nxt  = r_valid;
    w_cnt_nxt    = r_cnt;
    w_swclr_nxt  = '0;
    w_tout_nxt   = 1'b0;
    w_ptr_nxt    = commandReg[4] ? r_ptr : '0;
    case (r_state)
      S_IDLE: begin
        if (w_found && !commandReg[2]) begin
          w_state_nxt  = S_GRANT;
          w_active_nxt = w_sel;
          w_valid_nxt  = NCH'(1) << w_sel;
          w_cnt_nxt    = '0;
        end
      end
      S_GRANT: begin
        if (validDACK) begin
          w_state_nxt = S_SERVICE;
        end else if (!w_eff[r_active_ch]) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = '0;
        end else if (r_cnt == CW'(GRANT_TIMEOUT - 1)) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = '0;
          w_tout_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_SERVICE: begin
        if (svcDone) begin
          w_state_nxt = S_RELEASE;
          w_valid_nxt = '0;
          if (requestReg[r_active_ch]) begin
            w_swclr_nxt = NCH'(1) << r_active_ch;
          end
        end
      end
      S_RELEASE: begin
        w_state_nxt = S_IDLE;
        if (commandReg[4]) begin
          w_ptr_nxt = PW'((32'(r_active_ch) + 32'd1) % NCH);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_active_ch  <= '0;
      r_valid      <= '0;
      r_req_status <= '0;
      r_swclr      <= '0;
      r_busy       <= 1'b0;
      r_tout       <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_active_ch  <= w_active_nxt;
      r_valid      <= w_valid_nxt;
      r_req_status <= w_eff;
      r_swclr      <= w_swclr_nxt;
      r_busy       <= w_busy_nxt;
      r_tout       <= w_tout_nxt;
      r_cnt        <= w_cnt_nxt;
    end
  end

  // DACK is decoded from registered state so its polarity tracks commandReg[7] directly.
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      DACK[i] = (r_state == S_SERVICE && r_active_ch == PW'(i)) ? commandReg[7] : ~commandReg[7];
    end
  end

  assign VALID_DREQ   = r_valid;
  assign activeCh     = r_active_ch;
  assign busy         = r_busy;
  assign reqStatus    = r_req_status;
  assign swReqClr     = r_swclr;
  assign grantTimeout = r_tout;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: vector table of full services,
// grant scoreboard, and hand sequences for timeout, withdrawal, reset and disable.
module tb_dma_priority_arbiter;

  localparam int unsigned GT = 16;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic [3:0] requestReg;
  logic [7:0] commandReg;
  logic       validDACK;
  logic       svcDone;
  logic [3:0] VALID_DREQ;
  logic [3:0] DACK;
  logic [1:0] activeCh;
  logic       busy;
  logic [3:0] reqStatus;
  logic [3:0] swReqClr;
  logic       grantTimeout;

  dma_priority_arbiter #(.NCH(4), .GRANT_TIMEOUT(GT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .maskReg(maskReg),
    .requestReg(requestReg), .commandReg(commandReg), .validDACK(validDACK),
    .svcDone(svcDone), .VALID_DREQ(VALID_DREQ), .DACK(DACK), .activeCh(activeCh),
    .busy(busy), .reqStatus(reqStatus), .swReqClr(swReqClr), .grantTimeout(grantTimeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] cmd;
    logic [3:0] dreq;
    logic [3:0] mask;
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic [3:0] exp_eff;
    logic [3:0] exp_swclr;
  } vec_t;

  vec_t       vecs[8];
  logic [3:0] exp_q[$];
  logic [3:0] prev_valid;
  int         n_checks;
  int         n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int unsigned oh_idx(input logic [3:0] v);
    for (int unsigned i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Each new grant (VALID_DREQ rising) is popped against the scoreboard.
  initial prev_valid = 4'b0;
  always @(negedge CLK) begin
    if (VALID_DREQ != 4'b0 && prev_valid == 4'b0) begin
      if (exp_q.size() == 0) chk("sb_unexpected_grant", 32'(VALID_DREQ), 32'd0);
      else chk("sb_grant", 32'(VALID_DREQ), 32'(exp_q.pop_front()));
    end
    prev_valid <= VALID_DREQ;
  end

  task automatic wait_grant(output int unsigned lat);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      lat++;
      if (VALID_DREQ != 4'b0) break;
    end
  endtask

  task automatic do_service(input logic [7:0] cmd, input logic [3:0] exp_grant,
                            input logic [3:0] exp_eff, input logic [3:0] exp_swclr,
                            input string tag);
    int unsigned lat;
    logic [3:0]  dack_idle;
    logic [3:0]  dack_svc;
    dack_idle = {4{~cmd[7]}};
    dack_svc  = cmd[7] ? exp_grant : ~exp_grant;
    exp_q.push_back(exp_grant);
    wait_grant(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd1);
    chk({tag, "_busy_grant"}, 32'(busy), 32'd1);
    chk({tag, "_activech"}, 32'(activeCh), 32'(oh_idx(exp_grant)));
    chk({tag, "_dack_grant"}, 32'(DACK), 32'(dack_idle));
    chk({tag, "_reqstatus"}, 32'(reqStatus), 32'(exp_eff));
    validDACK = 1'b1;
    tick();
    validDACK = 1'b0;
    chk({tag, "_dack_svc"}, 32'(DACK), 32'(dack_svc));
    chk({tag, "_valid_svc"}, 32'(VALID_DREQ), 32'(exp_grant));
    svcDone = 1'b1;
    tick();
    svcDone = 1'b0;
    chk({tag, "_valid_rel"}, 32'(VALID_DREQ), 32'd0);
    chk({tag, "_swclr_rel"}, 32'(swReqClr), 32'(exp_swclr));
    chk({tag, "_dack_rel"}, 32'(DACK), 32'(dack_idle));
    chk({tag, "_busy_rel"}, 32'(busy), 32'd1);
    tick();
    chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
    chk({tag, "_swclr_idle"}, 32'(swReqClr), 32'd0);
  endtask

  initial begin
    int unsigned lat;
    int unsigned n;
    logic        seen;
    logic [3:0]  rot_exp[5];

    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{cmd: 8'h00, dreq: 4'b1010, mask: 4'b0000, req: 4'b0000, exp_grant: 4'b0010, exp_eff: 4'b1010, exp_swclr: 4'b0000};
    vecs[1] = '{cmd: 8'h00, dreq: 4'b1010, mask: 4'b0000, req: 4'b0000, exp_grant: 4'b0010, exp_eff: 4'b1010, exp_swclr: 4'b0000};
    vecs[2] = '{cmd: 8'hC0, dreq: 4'b1011, mask: 4'b0001, req: 4'b0000, exp_grant: 4'b0100, exp_eff: 4'b0100, exp_swclr: 4'b0000};
    vecs[3] = '{cmd: 8'h00, dreq: 4'b0000, mask: 4'b1111, req: 4'b1000, exp_grant: 4'b1000, exp_eff: 4'b1000, exp_swclr: 4'b1000};
    vecs[4] = '{cmd: 8'h00, dreq: 4'b0001, mask: 4'b0001, req: 4'b0100, exp_grant: 4'b0100, exp_eff: 4'b0100, exp_swclr: 4'b0100};
    vecs[5] = '{cmd: 8'h80, dreq: 4'b1100, mask: 4'b0100, req: 4'b0000, exp_grant: 4'b1000, exp_eff: 4'b1000, exp_swclr: 4'b0000};
    vecs[6] = '{cmd: 8'h40, dreq: 4'b1110, mask: 4'b0000, req: 4'b0000, exp_grant: 4'b0001, exp_eff: 4'b0001, exp_swclr: 4'b0000};
    vecs[7] = '{cmd: 8'h00, dreq: 4'b1111, mask: 4'b0011, req: 4'b0010, exp_grant: 4'b0010, exp_eff: 4'b1110, exp_swclr: 4'b0010};
    rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    RESET_N = 1'b0; DREQ = 4'b0; maskReg = 4'b0; requestReg = 4'b0;
    commandReg = 8'h00; validDACK = 1'b0; svcDone = 1'b0;
    repeat (3) @(posedge CLK);
    #3 RESET_N = 1'b1;
    tick();
    chk("rst_valid", 32'(VALID_DREQ), 32'd0);
    chk("rst_dack", 32'(DACK), 32'hF);
    chk("rst_activech", 32'(activeCh), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reqstatus", 32'(reqStatus), 32'd0);
    chk("rst_swclr", 32'(swReqClr), 32'd0);
    chk("rst_timeout", 32'(grantTimeout), 32'd0);

    for (int v = 0; v < 8; v++) begin
      commandReg = vecs[v].cmd; DREQ = vecs[v].dreq;
      maskReg = vecs[v].mask; requestReg = vecs[v].req;
      do_service(vecs[v].cmd, vecs[v].exp_grant, vecs[v].exp_eff, vecs[v].exp_swclr,
                 $sformatf("vec%0d", v));
    end
    DREQ = 4'b0; maskReg = 4'b0; requestReg = 4'b0; commandReg = 8'h00;
    tick();

    // Rotating priority: every channel served once, then wrap to ch0.
    commandReg = 8'h10; DREQ = 4'b1111;
    for (int r = 0; r < 5; r++) do_service(8'h10, rot_exp[r], 4'b1111, 4'b0000, $sformatf("rot%0d", r));
    DREQ = 4'b0; commandReg = 8'h00;
    tick();

    // Grant never acknowledged: aborted after GT cycles in GRANT.
    DREQ = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant(lat);
    chk("to_latency", 32'(lat), 32'd1);
    n = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      n++;
      if (grantTimeout) seen = 1'b1;
      else if (n == GT - 1) chk("to_valid_held", 32'(VALID_DREQ), 32'h1);
    end
    chk("to_cycles", 32'(n), 32'(GT));
    chk("to_valid_cleared", 32'(VALID_DREQ), 32'd0);
    DREQ = 4'b0;
    tick();
    chk("to_pulse_single", 32'(grantTimeout), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);

    // Request withdrawn while in GRANT.
    DREQ = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant(lat);
    chk("wd_latency", 32'(lat), 32'd1);
    DREQ = 4'b0;
    tick();
    chk("wd_valid", 32'(VALID_DREQ), 32'd0);
    chk("wd_busy", 32'(busy), 32'd0);
    chk("wd_timeout", 32'(grantTimeout), 32'd0);

    // Asynchronous reset in the middle of a service.
    DREQ = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant(lat);
    validDACK = 1'b1;
    tick();
    validDACK = 1'b0;
    chk("ar_dack_svc", 32'(DACK), 32'hD);
    #2 RESET_N = 1'b0;
    #1;
    chk("ar_valid", 32'(VALID_DREQ), 32'd0);
    chk("ar_dack", 32'(DACK), 32'hF);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_activech", 32'(activeCh), 32'd0);
    chk("ar_reqstatus", 32'(reqStatus), 32'd0);
    DREQ = 4'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();

    // Disable set mid-service: service completes, no further grant.
    DREQ = 4'b0100;
    exp_q.push_back(4'b0100);
    wait_grant(lat);
    validDACK = 1'b1;
    tick();
    validDACK = 1'b0;
    commandReg = 8'h04; DREQ = 4'b0001; maskReg = 4'b0100;
    tick();
    tick();
    chk("dis_dack_locked", 32'(DACK), 32'hB);
    chk("dis_valid_locked", 32'(VALID_DREQ), 32'h4);
    chk("dis_activech", 32'(activeCh), 32'd2);
    svcDone = 1'b1;
    tick();
    svcDone = 1'b0;
    chk("dis_valid_rel", 32'(VALID_DREQ), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("dis_no_grant", 32'(VALID_DREQ), 32'd0);
      chk("dis_idle", 32'(busy), 32'd0);
    end
    DREQ = 4'b0; maskReg = 4'b0; commandReg = 8'h00;
    tick();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
Name: dma_priority_arbiter

Overview:
Request resolver for the 4-channel DMA controller. It samples hardware DREQ lines and software requests, applies masking, polarity and fixed/rotating priority, and presents one granted channel to the timing-control FSM as a one-hot VALID_DREQ. It drives the channel DACK lines for the duration of the service and updates the rotation pointer once the service completes.

Parameters:
NCH, 4, number of DMA channels; the pointer width is $clog2(NCH).
GRANT_TIMEOUT, 16, maximum cycles spent in GRANT waiting for validDACK before the grant is aborted.

Ports:
CLK  input  1  system clock; all state updates on its rising edge.
RESET_N  input  1  asynchronous active-low reset.
DREQ  input  NCH  hardware DMA requests, already synchronized externally.
maskReg  input  NCH  per-channel mask; 1 = hardware request ignored.
requestReg  input  NCH  software request bits.
commandReg  input  8  bit2 = controller disable, bit4 = rotating priority, bit6 = DREQ active-low, bit7 = DACK active-high.
validDACK  input  1  from timing control: the service cycle has started (S1).
svcDone  input  1  single-cycle pulse from timing control at the end of the service (S4 or EOP).
VALID_DREQ  output  NCH  registered one-hot grant to timing control.
DACK  output  NCH  channel acknowledge, with programmable polarity.
activeCh  output  $clog2(NCH)  index of the granted channel.
busy  output  1  high in GRANT, SERVICE and RELEASE.
reqStatus  output  NCH  registered effective requests; feeds statusReg[7:4].
swReqClr  output  NCH  one-cycle pulse that clears the serviced software request bit.
grantTimeout  output  1  one-cycle pulse when a grant is aborted.

Behaviour:
- Effective request per channel:
  - eff[i] = ((DREQ[i] ^ commandReg[6]) & ~maskReg[i]) | requestReg[i].
  - Software requests ignore the mask.
- DACK level:
  - dackOn = commandReg[7].
  - DACK[i] = dackOn when i == activeCh and state == SERVICE; otherwise ~dackOn.
  - DACK polarity follows commandReg[7] combinationally.
- Priority pointer ptr:
  - Highest-priority channel is ptr, then ptr+1, … mod NCH.
  - When commandReg[4] = 0, ptr is forced to 0 each cycle (fixed priority, ch0 highest).
  - In rotating mode, RELEASE of channel k loads ptr = (k+1) mod NCH, so k becomes lowest.
- Reset (RESET_N low, asynchronous, including mid-service):
  - state = IDLE, ptr = 0, VALID_DREQ = 0, activeCh = 0, busy = 0, reqStatus = 0, swReqClr = 0, grantTimeout = 0, timeout counter = 0.
  - DACK = all ~commandReg[7].
- reqStatus <= eff every cycle (1-cycle latency).
- State machine:
  - IDLE:
    - If eff != 0 and commandReg[2] = 0: select the highest-priority channel, register activeCh and the one-hot VALID_DREQ, clear the counter, go to GRANT.
    - Grant latency is 1 cycle from eff asserting.
  - GRANT:
    - VALID_DREQ held.
    - validDACK = 1: go to SERVICE.
    - Else if eff[activeCh] = 0 (request withdrawn): clear VALID_DREQ, go to IDLE, no pointer update.
    - Else if the counter reaches GRANT_TIMEOUT-1: clear VALID_DREQ, pulse grantTimeout, go to IDLE.
    - Otherwise increment the counter.
  - SERVICE:
    - DACK active and VALID_DREQ held.
    - Request changes, mask changes and a commandReg[2] set are all ignored; the grant is locked until svcDone.
    - svcDone = 1: go to RELEASE.
  - RELEASE (one cycle):
    - VALID_DREQ = 0, DACK inactive.
    - Pulse swReqClr[activeCh] if requestReg[activeCh] = 1.
    - Update ptr, go to IDLE.
    - A fresh arbitration takes place in IDLE on the next cycle, so there is a minimum 1 idle cycle between grants.
- svcDone or validDACK arriving in an unexpected state is ignored.
- The controller disable (commandReg[2] = 1) blocks only new grants from IDLE.

Test Plan:
1. Fixed priority, DREQ = 4'b1010 held, commandReg = 0 -> VALID_DREQ = 4'b0010 one cycle later; after validDACK then svcDone -> next grant is 4'b0010 again (ch1 re-wins).
2. Rotating priority, commandReg[4] = 1, DREQ = 4'b1111 held, four full services -> grant order ch0, ch1, ch2, ch3, then ch0.
3. commandReg[6] = 1, commandReg[7] = 1, DREQ = 4'b1011, maskReg = 4'b0001 -> ch2 granted; DACK = 4'b0100 during SERVICE and 4'b0000 otherwise.
4. Grant to ch0 with validDACK never asserted -> grantTimeout pulse exactly GRANT_TIMEOUT cycles after entering GRANT; VALID_DREQ = 0 the following cycle.
5. requestReg = 4'b1000 with maskReg = 4'b1111 -> ch3 granted; swReqClr = 4'b1000 for one cycle in RELEASE.
6. RESET_N pulled low during SERVICE -> outputs return to reset values immediately without waiting for a clock edge; commandReg[2] = 1 set during SERVICE -> the current service completes and no new grant is issued.
